imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch-to-imem interface.
- Accepts PC requests from the fetch stage and returns the instruction word, the echoed PC and a fault flag after a fixed pipelined latency.
- Supports backpressure, flush on taken branch, and a side-band load port for program preload by the testbench or boot logic.

---
 rtl/imem_responder_if.sv | 32 +++
 rtl/imem_responder.sv | 91 +++++++++
 tb/tb_imem_responder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-to-imem bus: request, response and preload side-band.
// Signal names keep the responder-side _i/_o suffixes.
interface imem_responder_if #(
    parameter int unsigned DEPTH_WORDS = 1024
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic          req_valid_i;
    logic          req_ready_o;
    logic [31:0]   req_pc_i;
    logic          flush_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_pc_o;
    logic [31:0]   rsp_instr_o;
    logic          rsp_fault_o;
    logic          load_we_i;
    logic [AW-1:0] load_addr_i;
    logic [31:0]   load_data_i;

    modport slave (
        input  req_valid_i, req_pc_i, flush_i, rsp_ready_i,
               load_we_i, load_addr_i, load_data_i,
        output req_ready_o, rsp_valid_o, rsp_pc_o, rsp_instr_o, rsp_fault_o
    );

    modport master (
        output req_valid_i, req_pc_i, flush_i, rsp_ready_i,
               load_we_i, load_addr_i, load_data_i,
        input  req_ready_o, rsp_valid_o, rsp_pc_o, rsp_instr_o, rsp_fault_o
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: reads at acceptance, returns {pc, instr, fault}
// after LATENCY stages, with whole-pipeline stall, flush and a preload port.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    imem_responder_if.slave  bus
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned LAST  = LATENCY - 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    // Upper bound held in 33 bits so a base near the top of memory cannot wrap.
    localparam logic [32:0] UPPER = 33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] rd_idx;
    logic          req_fault;
    logic          adv;
    logic          accept;

    logic [LATENCY-1:0]       valid_q, valid_d;
    logic [LATENCY-1:0][31:0] pc_q, pc_d;
    logic [LATENCY-1:0][31:0] instr_q, instr_d;
    logic [LATENCY-1:0]       fault_q, fault_d;

    always_comb begin
        rd_idx    = AW'((bus.req_pc_i - BASE_ADDR) >> 2);
        req_fault = (|bus.req_pc_i[1:0])
                  | (bus.req_pc_i < BASE_ADDR)
                  | ({1'b0, bus.req_pc_i} >= UPPER);
        adv       = ~valid_q[LAST] | bus.rsp_ready_i;
        accept    = bus.req_valid_i & adv;
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (adv) begin
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                pc_d[i]    = pc_q[i-1];
                instr_d[i] = instr_q[i-1];
                fault_d[i] = fault_q[i-1];
            end
            valid_d[0] = accept;
            if (accept) begin
                pc_d[0]    = bus.req_pc_i;
                instr_d[0] = req_fault ? NOP : mem_q[rd_idx];
                fault_d[0] = req_fault;
            end
        end
        // Flush kills everything in flight but keeps the post-branch request.
        if (bus.flush_i) begin
            valid_d    = '0;
            valid_d[0] = accept;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            fault_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Non-blocking write: a same-edge read at acceptance sees the old word.
    always_ff @(posedge clk_i) begin
        if (bus.load_we_i) begin
            mem_q[bus.load_addr_i] <= bus.load_data_i;
        end
    end

    assign bus.req_ready_o = adv;
    assign bus.rsp_valid_o = valid_q[LAST];
    assign bus.rsp_pc_o    = pc_q[LAST];
    assign bus.rsp_instr_o = instr_q[LAST];
    assign bus.rsp_fault_o = fault_q[LAST];
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: queue-based reference model checked
// every cycle, plus literal expectations on the transferred response stream.
module tb_imem_responder;
    localparam int unsigned L    = 2;
    localparam int unsigned D    = 1024;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    imem_responder_if #(.DEPTH_WORDS(D)) bus ();

    imem_responder #(
        .DEPTH_WORDS(D),
        .LATENCY    (L),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        int unsigned age;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    ent_t        mq[$];
    logic [31:0] mmem [D];
    rsp_t        xfer[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    function automatic bit head_vis();
        return (mq.size() > 0) && (mq[0].age >= L - 1);
    endfunction

    // Reference: in-flight requests as an ordered queue with an age counted
    // in advancing cycles; the head is visible once it has aged LATENCY-1.
    bit          m_hv, m_adv;
    ent_t        m_e;
    logic [31:0] m_w;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
        end else begin
            m_hv  = head_vis();
            m_adv = !m_hv || bus.rsp_ready_i;
            if (m_adv && m_hv) void'(mq.pop_front());
            if (m_adv) foreach (mq[i]) mq[i].age++;
            if (bus.flush_i) mq.delete();
            if (m_adv && bus.req_valid_i) begin
                m_w       = bus.req_pc_i;
                m_e.pc    = m_w;
                m_e.age   = 0;
                m_e.fault = (m_w % 4 != 0) || (m_w < BASE) || ((m_w - BASE) >= 4 * D);
                m_e.instr = m_e.fault ? 32'h0000_0013 : mmem[(m_w - BASE) / 4];
                mq.push_back(m_e);
            end
            if (bus.load_we_i) mmem[bus.load_addr_i] = bus.load_data_i;
        end
    end

    bit   c_hv;
    rsp_t c_r;
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rsp_valid_in_reset", bus.rsp_valid_o, 0);
        end else begin
            c_hv = head_vis();
            chk("req_ready", bus.req_ready_o, !c_hv || bus.rsp_ready_i);
            chk("rsp_valid", bus.rsp_valid_o, c_hv);
            if (c_hv) begin
                chk("rsp_pc", bus.rsp_pc_o, mq[0].pc);
                chk("rsp_instr", bus.rsp_instr_o, mq[0].instr);
                chk("rsp_fault", bus.rsp_fault_o, mq[0].fault);
            end
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                c_r.pc    = bus.rsp_pc_o;
                c_r.instr = bus.rsp_instr_o;
                c_r.fault = bus.rsp_fault_o;
                xfer.push_back(c_r);
            end
        end
    end

    task cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] pc);
        bit acc = 1'b0;
        int t   = 0;
        bus.req_valid_i = 1'b1;
        bus.req_pc_i    = pc;
        while (!acc && t < 50) begin
            #1;
            acc = bus.req_ready_o;
            @(posedge clk);
            #2;
            t++;
        end
        if (!acc) fail("send_accept");
        bus.req_valid_i = 1'b0;
    endtask

    task automatic load(input int unsigned a, input logic [31:0] d);
        bus.load_we_i   = 1'b1;
        bus.load_addr_i = a[9:0];
        bus.load_data_i = d;
        cyc();
        bus.load_we_i = 1'b0;
    endtask

    task automatic wait_xfer(input int n);
        int t = 0;
        while (xfer.size() < n && t < 50) begin
            cyc();
            t++;
        end
        if (xfer.size() < n) fail("wait_xfer");
        repeat (3) cyc();
    endtask

    task automatic chk_rsp(input string nm, input int idx, input logic [31:0] pc,
                           input logic [31:0] instr, input logic fault);
        if (idx >= xfer.size()) begin
            fail(nm);
        end else begin
            chk({nm, "_pc"}, xfer[idx].pc, pc);
            chk({nm, "_instr"}, xfer[idx].instr, instr);
            chk({nm, "_fault"}, xfer[idx].fault, fault);
        end
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_pc_i    = '0;
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.load_we_i   = 1'b0;
        bus.load_addr_i = '0;
        bus.load_data_i = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("reset_valid", bus.rsp_valid_o, 0);
        chk("reset_pc", bus.rsp_pc_o, 32'h0);
        chk("reset_instr", bus.rsp_instr_o, 32'h0);
        chk("reset_fault", bus.rsp_fault_o, 0);
        cyc();
        rstn = 1'b1;
        cyc();
        #1 chk("reset_ready", bus.req_ready_o, 1);

        // Streaming with no backpressure; first response one cycle after accept.
        load(0, 32'h0000_0011);
        load(1, 32'h0000_0022);
        load(2, 32'h0000_0033);
        load(3, 32'h0000_0044);
        bus.rsp_ready_i = 1'b1;
        send(32'h8000_0000);
        chk("t1_lat_edge0", bus.rsp_valid_o, 0);
        send(32'h8000_0004);
        chk("t1_lat_edge1", bus.rsp_valid_o, 1);
        chk("t1_lat_pc", bus.rsp_pc_o, 32'h8000_0000);
        send(32'h8000_0008);
        send(32'h8000_000C);
        wait_xfer(4);
        chk("t1_count", xfer.size(), 4);
        chk_rsp("t1_r0", 0, 32'h8000_0000, 32'h0000_0011, 1'b0);
        chk_rsp("t1_r1", 1, 32'h8000_0004, 32'h0000_0022, 1'b0);
        chk_rsp("t1_r2", 2, 32'h8000_0008, 32'h0000_0033, 1'b0);
        chk_rsp("t1_r3", 3, 32'h8000_000C, 32'h0000_0044, 1'b0);
        xfer.delete();

        // Backpressure for three cycles once the first response shows.
        bus.rsp_ready_i = 1'b0;
        fork
            begin
                send(32'h8000_0000);
                send(32'h8000_0004);
                send(32'h8000_0008);
                send(32'h8000_000C);
            end
            begin
                int t = 0;
                while (!bus.rsp_valid_o && t < 20) begin
                    cyc();
                    t++;
                end
                if (!bus.rsp_valid_o) fail("t2_first_valid");
                repeat (3) begin
                    #1;
                    chk("t2_hold_ready", bus.req_ready_o, 0);
                    chk("t2_hold_pc", bus.rsp_pc_o, 32'h8000_0000);
                    chk("t2_hold_instr", bus.rsp_instr_o, 32'h0000_0011);
                    @(posedge clk);
                    #2;
                end
                bus.rsp_ready_i = 1'b1;
            end
        join
        wait_xfer(4);
        chk("t2_count", xfer.size(), 4);
        chk_rsp("t2_r0", 0, 32'h8000_0000, 32'h0000_0011, 1'b0);
        chk_rsp("t2_r1", 1, 32'h8000_0004, 32'h0000_0022, 1'b0);
        chk_rsp("t2_r2", 2, 32'h8000_0008, 32'h0000_0033, 1'b0);
        chk_rsp("t2_r3", 3, 32'h8000_000C, 32'h0000_0044, 1'b0);
        xfer.delete();

        // Flush with the branch target presented in the same cycle. The head
        // entry is being transferred on the flush edge, so it counts as consumed;
        // 8000_0004 is discarded.
        send(32'h8000_0000);
        send(32'h8000_0004);
        bus.flush_i = 1'b1;
        send(32'h8000_0008);
        bus.flush_i = 1'b0;
        wait_xfer(2);
        chk("t3_count", xfer.size(), 2);
        chk_rsp("t3_r0", 0, 32'h8000_0000, 32'h0000_0011, 1'b0);
        chk_rsp("t3_r1", 1, 32'h8000_0008, 32'h0000_0033, 1'b0);
        xfer.delete();

        // Fault cases plus the last in-range word.
        load(1023, 32'hDEAD_BEEF);
        send(32'h8000_0002);
        send(32'h7FFF_FFFC);
        send(32'h8000_1000);
        send(32'hFFFF_FFFC);
        send(32'h8000_0FFC);
        wait_xfer(5);
        chk("t4_count", xfer.size(), 5);
        chk_rsp("t4_misalign", 0, 32'h8000_0002, 32'h0000_0013, 1'b1);
        chk_rsp("t4_below", 1, 32'h7FFF_FFFC, 32'h0000_0013, 1'b1);
        chk_rsp("t4_above", 2, 32'h8000_1000, 32'h0000_0013, 1'b1);
        chk_rsp("t4_top", 3, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
        chk_rsp("t4_last", 4, 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0);
        xfer.delete();

        // Load on the same edge as a read of that word returns the old data.
        bus.load_we_i   = 1'b1;
        bus.load_addr_i = 10'd1;
        bus.load_data_i = 32'hAAAA_AAAA;
        send(32'h8000_0004);
        bus.load_we_i = 1'b0;
        send(32'h8000_0004);
        wait_xfer(2);
        chk("t5_count", xfer.size(), 2);
        chk_rsp("t5_old", 0, 32'h8000_0004, 32'h0000_0022, 1'b0);
        chk_rsp("t5_new", 1, 32'h8000_0004, 32'hAAAA_AAAA, 1'b0);
        xfer.delete();

        // Asynchronous reset with two entries in flight.
        bus.rsp_ready_i = 1'b0;
        send(32'h8000_0000);
        send(32'h8000_0004);
        chk("t6_pre_valid", bus.rsp_valid_o, 1);
        rstn = 1'b0;
        #1;
        chk("t6_async_valid", bus.rsp_valid_o, 0);
        cyc();
        rstn = 1'b1;
        bus.rsp_ready_i = 1'b1;
        repeat (5) cyc();
        chk("t6_no_stale", xfer.size(), 0);
        #1 chk("t6_ready", bus.req_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
